reg_wb_ctrl: RTL and testbench
==============================

# reg_wb_ctrl

Writeback controller and scoreboard on the write side of `reg_file`. It merges register results from the single-cycle ALU path and the variable-latency memory path onto the register file's single write port (`regWrite`/`writeReg`/`writeData`). It tracks a busy bit per architectural register and stalls decode until every pending write an instruction depends on has landed. It sits between the execute/memory stages and `reg_file`, alongside decode.

## Interface
- `DATA_W`, default 32: register data width.
- `REG_AW`, default 5: register address width; the block tracks 2^REG_AW registers.
- `FIFO_DEPTH`, default 4: depth of the memory-result buffer; must be a power of two and at least 2.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `issue_valid` in 1: decode presents an instruction.
- `issue_rs`, `issue_rt` in REG_AW: source registers.
- `issue_rd` in REG_AW: destination register.
- `issue_wr` in 1: the instruction writes `issue_rd`.
- `issue_stall` out 1: combinational; decode must hold the instruction.
- `alu_wb_valid` in 1: ALU result valid this cycle; it cannot be back-pressured.
- `alu_wb_reg` in REG_AW, `alu_wb_data` in DATA_W: ALU result.
- `mem_wb_valid` in 1, `mem_wb_ready` out 1: memory-result handshake.
- `mem_wb_reg` in REG_AW, `mem_wb_data` in DATA_W: memory result.
- `regWrite` out 1, `writeReg` out REG_AW, `writeData` out DATA_W: registered; connect directly to `reg_file`.
- `wb_err` out 1: sticky; set when a writeback targets a register that is not busy.

## Operation
- Scoreboard: `busy[2^REG_AW-1:0]`. Register 0 is never marked busy.
- Issue is accepted when `issue_valid && !issue_stall`. On acceptance with `issue_wr && issue_rd!=0`, `busy[issue_rd]` is set at the next edge.
- `issue_stall = issue_valid && (busy[issue_rs] || busy[issue_rt] || (issue_wr && busy[issue_rd]))`. The last term is the WAW check.
- Memory FIFO: a push occurs on `mem_wb_valid && mem_wb_ready`. `mem_wb_ready = !full`. There is no push while full, even if a pop happens in the same cycle.
- Arbitration each cycle: the ALU has strict priority. If `alu_wb_valid`, the ALU result is selected. Otherwise, if the FIFO is non-empty, the FIFO head is popped and selected.
- The selected result is registered onto `writeReg`/`writeData`. `regWrite` is registered as `selected && reg!=0`. A write to register 0 is dropped and leaves `busy` untouched.
- `busy[writeReg]` clears at the edge that ends the cycle in which `regWrite=1`. `reg_file` captures the data at that same edge.
- Set and clear on the same register in the same cycle cannot occur, because the WAW term stalls that issue. No priority rule is needed.
- `wb_err` sets when a selected writeback with reg!=0 finds `busy[reg]==0`. It clears only on `rst`.

## Timing
- ALU result valid in cycle N: `regWrite=1` in N+1; register file and busy bit update at the end of N+1.
- A dependent instruction stalls through N+1 and issues in N+2, reading the new value from `reg_file`.
- Memory result pushed in cycle N into an empty FIFO with no ALU traffic: popped in N+1, `regWrite` in N+2.
- Each ALU-valid cycle delays a FIFO pop by one cycle. Sustained ALU traffic starves the FIFO; `mem_wb_ready` falls once the FIFO fills.
- Reset values: `regWrite=0`, `writeReg=0`, `writeData=0`, `wb_err=0`, all `busy=0`, FIFO empty, `mem_wb_ready=1` from the first cycle after reset.
- A reset asserted mid-operation discards buffered results and pending busy bits. `regWrite` is 0 in the cycle after `rst` is sampled high.

## Configuration
- `REG_WB_BYPASS_EN` defined:
  - Adds outputs `fwd_rs_hit`, `fwd_rt_hit` (1 bit each) and `fwd_data` (DATA_W, equal to `writeData`).
  - When `regWrite && writeReg==issue_rs`, the rs term is removed from `issue_stall` and `fwd_rs_hit=1`; the rt term is handled identically with `fwd_rt_hit`.
  - The dependent instruction issues in N+1 instead of N+2.
- `REG_WB_BYPASS_EN` undefined: the ports are absent and the stall rules above apply unchanged.

## Structure
- Shared package `reg_wb_pkg`: `REG_AW`/`DATA_W` defaults, the `wb_req_t` struct {reg, data}, and the `REG_ZERO` constant.
- One sub-module: `wb_fifo`, a synchronous FIFO with FIFO_DEPTH entries, pointers one bit wider than the index for full/empty, and a combinational head output. All other logic lives in `reg_wb_ctrl`.

## Test plan
- Issue rd=5 (wr), next cycle issue rs=5: `issue_stall=1`. After ALU writeback of reg 5 = 0xDEADBEEF, `regWrite` pulses once and the stall drops two cycles after the ALU valid.
- ALU writeback (reg 3) and memory push (reg 4) in the same cycle: reg 3 is written in N+1, reg 4 in N+2, and both busy bits clear.
- Hold `alu_wb_valid` high for 6 cycles while memory pushes every cycle: `mem_wb_ready` falls after 4 pushes; the FIFO drains in order once the ALU goes idle.
- Writeback to reg 0 with data 0x1234: `regWrite` stays 0 and `wb_err` stays 0. Issue with rd=0 never stalls a later reader of reg 0.
- Writeback to a non-busy reg 7: write occurs and `wb_err` becomes 1 and stays 1 until `rst`.
- Assert `rst` with 3 FIFO entries and 2 busy bits: afterwards no `regWrite`, `issue_stall=0`, `mem_wb_ready=1`. With `REG_WB_BYPASS_EN`, repeat the first scenario: the reader issues in N+1 with `fwd_rs_hit=1`.

Source files
------------

// File: rtl/reg_wb_pkg.sv
// ----------------------------------------------------------------------------
// reg_wb_pkg
// Shared definitions for the register writeback controller:
//   REG_AW_DFLT / DATA_W_DFLT : default register address / data widths
//   REG_ZERO                  : architectural zero register (never written,
//                               never marked busy)
//   wb_req_t                  : one writeback request {wreg, data} at the
//                               default widths
// ----------------------------------------------------------------------------
package reg_wb_pkg;

   localparam int REG_AW_DFLT = 5;
   localparam int DATA_W_DFLT = 32;

   localparam int unsigned REG_ZERO = 0;

   typedef struct packed {
      logic [REG_AW_DFLT-1:0] wreg;
      logic [DATA_W_DFLT-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/reg_wb_ctrl_wb_fifo.sv
// ----------------------------------------------------------------------------
// wb_fifo
// Synchronous FIFO buffering memory-path writeback results until the
// register file write port is free.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (pointers only)
//   i_push    : write i_data (ignored while full)
//   i_data    : entry to write
//   i_pop     : retire the head entry (ignored while empty)
//   o_head    : combinational view of the oldest entry
//   o_full    : DEPTH entries held
//   o_empty   : no entries held
// DEPTH must be a power of two and at least 2.
// ----------------------------------------------------------------------------
module wb_fifo
   import reg_wb_pkg::*;
#(
   parameter int W     = REG_AW_DFLT + DATA_W_DFLT,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic [W-1:0] o_head,
   output logic         o_full,
   output logic         o_empty
);

   localparam int AW = $clog2(DEPTH);

   // One extra pointer bit distinguishes full (wrapped) from empty.
   logic [AW:0]  r_wptr;
   logic [AW:0]  r_rptr;
   logic [W-1:0] r_mem [DEPTH];

   logic w_do_push;
   logic w_do_pop;

   assign o_empty   = (r_wptr == r_rptr);
   assign o_full    = (r_wptr[AW] != r_rptr[AW]) &&
                      (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign o_head    = r_mem[r_rptr[AW-1:0]];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + 1'b1;
         if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end

   // Storage carries data only; it needs no reset.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/reg_wb_ctrl.sv
// ----------------------------------------------------------------------------
// reg_wb_ctrl
// Writeback controller and scoreboard in front of reg_file. Merges the
// single-cycle ALU results and buffered memory results onto the single
// register-file write port and stalls decode on RAW/WAW hazards against
// registers with pending writes.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   issue_valid/rs/rt/rd/wr      : instruction presented by decode
//   issue_stall                  : combinational hold request to decode
//   alu_wb_valid/reg/data        : ALU result (never back-pressured)
//   mem_wb_valid/ready/reg/data  : memory result handshake
//   regWrite/writeReg/writeData  : registered write port to reg_file
//   wb_err                       : sticky, writeback to a non-busy register
// Optional build macro REG_WB_BYPASS_EN adds fwd_rs_hit, fwd_rt_hit and
// fwd_data so a source being written this cycle is forwarded instead of
// stalling.
// ----------------------------------------------------------------------------
module reg_wb_ctrl
   import reg_wb_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DFLT,
   parameter int REG_AW     = REG_AW_DFLT,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue_valid,
   input  logic [REG_AW-1:0] issue_rs,
   input  logic [REG_AW-1:0] issue_rt,
   input  logic [REG_AW-1:0] issue_rd,
   input  logic              issue_wr,
   output logic              issue_stall,
   input  logic              alu_wb_valid,
   input  logic [REG_AW-1:0] alu_wb_reg,
   input  logic [DATA_W-1:0] alu_wb_data,
   input  logic              mem_wb_valid,
   output logic              mem_wb_ready,
   input  logic [REG_AW-1:0] mem_wb_reg,
   input  logic [DATA_W-1:0] mem_wb_data,
   output logic              regWrite,
   output logic [REG_AW-1:0] writeReg,
   output logic [DATA_W-1:0] writeData,
   output logic              wb_err
`ifdef REG_WB_BYPASS_EN
   ,
   output logic              fwd_rs_hit,
   output logic              fwd_rt_hit,
   output logic [DATA_W-1:0] fwd_data
`endif
);

   localparam int NREG = 1 << REG_AW;
   localparam int EW   = REG_AW + DATA_W;
   localparam logic [REG_AW-1:0] RZ = REG_AW'(REG_ZERO);

   logic [NREG-1:0]   r_busy;
   logic [NREG-1:0]   w_busy_nxt;
   logic              r_regwrite;
   logic [REG_AW-1:0] r_writereg;
   logic [DATA_W-1:0] r_writedata;
   logic              r_wb_err;

   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;
   logic [EW-1:0]     w_head;

   logic              w_sel_vld;
   logic [REG_AW-1:0] w_sel_reg;
   logic [DATA_W-1:0] w_sel_data;
   logic              w_sel_nz;

   logic              w_rs_stall;
   logic              w_rt_stall;
   logic              w_rd_stall;
   logic              w_issue_acc;

   // ---- memory result buffer ----------------------------------------------
   // Ready depends only on full, so no push is taken while full even if the
   // head is popped in the same cycle.
   assign mem_wb_ready = !w_full;
   assign w_push       = mem_wb_valid && !w_full;

   wb_fifo #(
      .W     (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  ({mem_wb_reg, mem_wb_data}),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // ---- arbitration: ALU has strict priority over the FIFO head -----------
   always_comb begin
      w_sel_vld  = 1'b0;
      w_sel_reg  = '0;
      w_sel_data = '0;
      w_pop      = 1'b0;
      if (alu_wb_valid) begin
         w_sel_vld  = 1'b1;
         w_sel_reg  = alu_wb_reg;
         w_sel_data = alu_wb_data;
      end else if (!w_empty) begin
         w_sel_vld  = 1'b1;
         w_pop      = 1'b1;
         w_sel_reg  = w_head[EW-1:DATA_W];
         w_sel_data = w_head[DATA_W-1:0];
      end
   end

   assign w_sel_nz = (w_sel_reg != RZ);

   // ---- hazard detection ----------------------------------------------------
`ifdef REG_WB_BYPASS_EN
   // A source being written this cycle is covered by the forward path even
   // though its busy bit only clears at the end of the cycle.
   assign fwd_rs_hit = r_regwrite && (r_writereg == issue_rs);
   assign fwd_rt_hit = r_regwrite && (r_writereg == issue_rt);
   assign fwd_data   = r_writedata;
   assign w_rs_stall = r_busy[issue_rs] && !fwd_rs_hit;
   assign w_rt_stall = r_busy[issue_rt] && !fwd_rt_hit;
`else
   assign w_rs_stall = r_busy[issue_rs];
   assign w_rt_stall = r_busy[issue_rt];
`endif
   // WAW: a second writer of a busy register waits for the first to land.
   assign w_rd_stall  = issue_wr && r_busy[issue_rd];
   assign issue_stall = issue_valid && (w_rs_stall || w_rt_stall || w_rd_stall);
   assign w_issue_acc = issue_valid && !issue_stall;

   // ---- scoreboard update ---------------------------------------------------
   // Set and clear never hit the same register in one cycle: the WAW term
   // holds any issue whose rd is still busy.
   always_comb begin
      w_busy_nxt = r_busy;
      if (r_regwrite) w_busy_nxt[r_writereg] = 1'b0;
      if (w_issue_acc && issue_wr && (issue_rd != RZ)) w_busy_nxt[issue_rd] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) r_busy <= '0;
      else     r_busy <= w_busy_nxt;
   end

   // ---- write port register -------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_regwrite  <= 1'b0;
         r_writereg  <= '0;
         r_writedata <= '0;
         r_wb_err    <= 1'b0;
      end else begin
         r_regwrite <= w_sel_vld && w_sel_nz;
         if (w_sel_vld) begin
            r_writereg  <= w_sel_reg;
            r_writedata <= w_sel_data;
         end
         if (w_sel_vld && w_sel_nz && !r_busy[w_sel_reg]) r_wb_err <= 1'b1;
      end
   end

   assign regWrite  = r_regwrite;
   assign writeReg  = r_writereg;
   assign writeData = r_writedata;
   assign wb_err    = r_wb_err;

endmodule

// File: tb/tb_reg_wb_ctrl.sv
module tb_reg_wb_ctrl;
   import reg_wb_pkg::*;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int FD = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          issue_valid;
   logic [AW-1:0] issue_rs, issue_rt, issue_rd;
   logic          issue_wr;
   logic          issue_stall;
   logic          alu_wb_valid;
   logic [AW-1:0] alu_wb_reg;
   logic [DW-1:0] alu_wb_data;
   logic          mem_wb_valid;
   logic          mem_wb_ready;
   logic [AW-1:0] mem_wb_reg;
   logic [DW-1:0] mem_wb_data;
   logic          regWrite;
   logic [AW-1:0] writeReg;
   logic [DW-1:0] writeData;
   logic          wb_err;
`ifdef REG_WB_BYPASS_EN
   logic          fwd_rs_hit, fwd_rt_hit;
   logic [DW-1:0] fwd_data;
`endif

   always #5 clk = ~clk;

   reg_wb_ctrl #(.DATA_W(DW), .REG_AW(AW), .FIFO_DEPTH(FD)) dut (
      .clk          (clk),
      .rst          (rst),
      .issue_valid  (issue_valid),
      .issue_rs     (issue_rs),
      .issue_rt     (issue_rt),
      .issue_rd     (issue_rd),
      .issue_wr     (issue_wr),
      .issue_stall  (issue_stall),
      .alu_wb_valid (alu_wb_valid),
      .alu_wb_reg   (alu_wb_reg),
      .alu_wb_data  (alu_wb_data),
      .mem_wb_valid (mem_wb_valid),
      .mem_wb_ready (mem_wb_ready),
      .mem_wb_reg   (mem_wb_reg),
      .mem_wb_data  (mem_wb_data),
      .regWrite     (regWrite),
      .writeReg     (writeReg),
      .writeData    (writeData),
      .wb_err       (wb_err)
`ifdef REG_WB_BYPASS_EN
      ,
      .fwd_rs_hit   (fwd_rs_hit),
      .fwd_rt_hit   (fwd_rt_hit),
      .fwd_data     (fwd_data)
`endif
   );

   int checks = 0;
   int errors = 0;

   wb_req_t mq[$];   // reference memory buffer
   wb_req_t eq[$];   // expected register-file writes, in order

   typedef struct {
      logic          v;
      logic [AW-1:0] rs;
      logic [AW-1:0] rt;
      logic [AW-1:0] rd;
      logic          wr;
      logic          stall;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference behaviour, evaluated on the inputs sampled at each rising edge.
   task automatic model_step();
      wb_req_t t;
      bit      can_push;
      if (rst) begin
         mq.delete();
         eq.delete();
      end else begin
         can_push = (mq.size() < FD);
         if (alu_wb_valid) begin
            t.wreg = alu_wb_reg;
            t.data = alu_wb_data;
            if (t.wreg != 0) eq.push_back(t);
         end else if (mq.size() > 0) begin
            t = mq.pop_front();
            if (t.wreg != 0) eq.push_back(t);
         end
         if (mem_wb_valid && can_push) begin
            t.wreg = mem_wb_reg;
            t.data = mem_wb_data;
            mq.push_back(t);
         end
      end
   endtask

   task automatic sb_compare();
      wb_req_t a, e;
      if (regWrite === 1'b1) begin
         a.wreg = writeReg;
         a.data = writeData;
         if (eq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected_write: got reg %0d data %0h expected no write", a.wreg, a.data);
         end else begin
            e = eq.pop_front();
            chk("sb_writeback", 64'(a), 64'(e));
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      sb_compare();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle();
      issue_valid  = 1'b0;
      issue_rs     = '0;
      issue_rt     = '0;
      issue_rd     = '0;
      issue_wr     = 1'b0;
      alu_wb_valid = 1'b0;
      alu_wb_reg   = '0;
      alu_wb_data  = '0;
      mem_wb_valid = 1'b0;
      mem_wb_reg   = '0;
      mem_wb_data  = '0;
   endtask

   task automatic issue(input int rs, input int rt, input int rd, input bit wr);
      issue_valid = 1'b1;
      issue_rs    = AW'(rs);
      issue_rt    = AW'(rt);
      issue_rd    = AW'(rd);
      issue_wr    = wr;
   endtask

   task automatic alu(input int r, input logic [DW-1:0] d);
      alu_wb_valid = 1'b1;
      alu_wb_reg   = AW'(r);
      alu_wb_data  = d;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // busy = {5, 9} while the table runs
      vecs[0] = '{1'b0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b1};
      vecs[2] = '{1'b1, 5'd1, 5'd9, 5'd0, 1'b0, 1'b1};
      vecs[3] = '{1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1};
      vecs[4] = '{1'b1, 5'd1, 5'd2, 5'd9, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0};
      vecs[6] = '{1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0};
      vecs[7] = '{1'b1, 5'd9, 5'd5, 5'd0, 1'b0, 1'b1};

      // reset
      idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("rst_regWrite", 64'(regWrite), 64'd0);
      chk("rst_writeReg", 64'(writeReg), 64'd0);
      chk("rst_writeData", 64'(writeData), 64'd0);
      chk("rst_wb_err", 64'(wb_err), 64'd0);
      chk("rst_mem_ready", 64'(mem_wb_ready), 64'd1);
      issue(5, 9, 0, 1'b0);
      #1 chk("rst_no_stall", 64'(issue_stall), 64'd0);
      issue_valid = 1'b0;

      // mark 5 and 9 busy, then the stall table
      issue(1, 2, 5, 1'b1);
      tick();
      issue(1, 2, 9, 1'b1);
      tick();
      idle();
      foreach (vecs[i]) begin
         issue_valid = vecs[i].v;
         issue_rs    = vecs[i].rs;
         issue_rt    = vecs[i].rt;
         issue_rd    = vecs[i].rd;
         issue_wr    = vecs[i].wr;
         #1 chk($sformatf("vec%0d_stall", i), 64'(issue_stall), 64'(vecs[i].stall));
         issue_valid = 1'b0;
         tick();
      end
      alu(5, 32'h0000_0055);
      tick();
      alu(9, 32'h0000_0099);
      tick();
      idle();
      tick();
      tick();

      // RAW on rd=5 resolved by an ALU writeback
      issue(1, 2, 5, 1'b1);
      #1 chk("raw_producer_issue", 64'(issue_stall), 64'd0);
      tick();
      issue(5, 0, 0, 1'b0);
      alu(5, 32'hDEAD_BEEF);
      #1 chk("raw_stall_N", 64'(issue_stall), 64'd1);
      tick();
      alu_wb_valid = 1'b0;
      chk("raw_regWrite_N1", 64'(regWrite), 64'd1);
      chk("raw_writeReg_N1", 64'(writeReg), 64'd5);
      chk("raw_writeData_N1", 64'(writeData), 64'hDEAD_BEEF);
`ifdef REG_WB_BYPASS_EN
      chk("byp_stall_N1", 64'(issue_stall), 64'd0);
      chk("byp_rs_hit", 64'(fwd_rs_hit), 64'd1);
      chk("byp_rt_hit", 64'(fwd_rt_hit), 64'd0);
      chk("byp_data", 64'(fwd_data), 64'hDEAD_BEEF);
`else
      chk("raw_stall_N1", 64'(issue_stall), 64'd1);
`endif
      tick();
      chk("raw_regWrite_N2", 64'(regWrite), 64'd0);
      chk("raw_stall_N2", 64'(issue_stall), 64'd0);
      idle();
      tick();

      // simultaneous ALU (reg 3) and memory (reg 4) results
      issue(1, 2, 3, 1'b1);
      tick();
      issue(1, 2, 4, 1'b1);
      tick();
      idle();
      alu(3, 32'h0000_0333);
      mem_wb_valid = 1'b1;
      mem_wb_reg   = AW'(4);
      mem_wb_data  = 32'h0000_0444;
      tick();
      idle();
      chk("dual_first_reg", 64'(writeReg), 64'd3);
      chk("dual_first_we", 64'(regWrite), 64'd1);
      tick();
      chk("dual_second_reg", 64'(writeReg), 64'd4);
      chk("dual_second_data", 64'(writeData), 64'h444);
      tick();
      issue(3, 4, 3, 1'b1);
      #1 chk("dual_busy_cleared", 64'(issue_stall), 64'd0);
      issue_valid = 1'b0;
      tick();

      // ALU starvation fills the buffer, then it drains in order
      for (int i = 0; i < 10; i++) begin
         issue(1, 2, 10 + i, 1'b1);
         tick();
      end
      idle();
      for (int i = 0; i < 6; i++) begin
         alu(10 + i, DW'(32'h100 + i));
         mem_wb_valid = 1'b1;
         mem_wb_reg   = AW'(16 + i);
         mem_wb_data  = DW'(32'h200 + i);
         #1 chk($sformatf("fill_ready_%0d", i), 64'(mem_wb_ready), 64'(i < 4));
         tick();
      end
      idle();
      for (int i = 0; i < 8; i++) tick();
      chk("fill_drained_ready", 64'(mem_wb_ready), 64'd1);
      chk("fill_drained_queue", 64'(eq.size()), 64'd0);
      chk("fill_no_err", 64'(wb_err), 64'd0);

      // register 0 is never written and never busy
      alu(0, 32'h0000_1234);
      tick();
      idle();
      chk("r0_no_write", 64'(regWrite), 64'd0);
      chk("r0_no_err", 64'(wb_err), 64'd0);
      issue(1, 2, 0, 1'b1);
      tick();
      issue(0, 0, 0, 1'b0);
      #1 chk("r0_reader_no_stall", 64'(issue_stall), 64'd0);
      issue_valid = 1'b0;
      tick();

      // writeback to non-busy reg 7 sets the sticky error
      alu(7, 32'h0000_0777);
      tick();
      idle();
      chk("err_write", 64'(regWrite), 64'd1);
      chk("err_set", 64'(wb_err), 64'd1);
      tick();
      tick();
      chk("err_sticky", 64'(wb_err), 64'd1);

      // reset with 3 buffered results and 2 busy registers
      issue(1, 2, 20, 1'b1);
      tick();
      issue(1, 2, 21, 1'b1);
      tick();
      idle();
      for (int i = 0; i < 3; i++) begin
         alu(7, DW'(32'h70 + i));
         mem_wb_valid = 1'b1;
         mem_wb_reg   = AW'(22 + i);
         mem_wb_data  = DW'(32'h300 + i);
         tick();
      end
      idle();
      rst = 1'b1;
      #1 chk("midrst_err_before", 64'(wb_err), 64'd1);
      tick();
      rst = 1'b0;
      chk("midrst_regWrite", 64'(regWrite), 64'd0);
      chk("midrst_ready", 64'(mem_wb_ready), 64'd1);
      chk("midrst_err_clear", 64'(wb_err), 64'd0);
      issue(20, 21, 0, 1'b0);
      #1 chk("midrst_no_stall", 64'(issue_stall), 64'd0);
      issue_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("midrst_quiet_%0d", i), 64'(regWrite), 64'd0);
      end

      chk("final_queue_empty", 64'(eq.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
